// File: rtl/lsu_pkg.sv
// Shared encodings and types for the load/store unit: access sizes, FSM states,
// captured-request record and the misalignment check.
package lsu_pkg;
  localparam int DATA_W    = 32;
  localparam int NUM_LANES = DATA_W / 8;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic acc_err(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_RSV) || (size == SZ_H && lo[0]) || (size == SZ_W && lo != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_if.sv
// CPU request/response and dmem port bundle; slave is the LSU side.
interface lsu_if;
  import lsu_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write, mem_read
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane logic: load extract/extend and byte/half store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              uns,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ext,
  output logic [DATA_W-1:0] merged
);
  logic [4:0]           sh;
  logic [DATA_W-1:0]    shifted;
  logic [DATA_W-1:0]    wrep;
  logic [NUM_LANES-1:0] be;

  always_comb begin
    sh   = '0;
    be   = '1;
    wrep = wdata;
    case (size)
      SZ_B: begin
        sh   = {lane, 3'b000};
        be   = NUM_LANES'(1) << lane;
        wrep = {NUM_LANES{wdata[7:0]}};
      end
      SZ_H: begin
        sh   = {lane[1], 4'b0000};
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = rdata >> sh;

  always_comb begin
    ext = shifted;
    case (size)
      SZ_B: ext = {{(DATA_W-8){~uns & shifted[7]}}, shifted[7:0]};
      SZ_H: ext = {{(DATA_W-16){~uns & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // Only enabled lanes take store data; the rest keep the word read in RD.
  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    assign merged[8*b +: 8] = be[b] ? wrep[8*b +: 8] : rdata[8*b +: 8];
  end
endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding access FSM against a combinational-read dmem,
// with read-modify-write for sub-word stores.
module lsu
  import lsu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);
  state_t            state, nxt;
  req_t              rq;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ext, merged;
  logic              accept, req_err;

  assign accept  = bus.req_valid && bus.req_ready;
  assign req_err = acc_err(bus.req_size, bus.req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rq      <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        rq    <= '{we: bus.req_we, size: bus.req_size, uns: bus.req_unsigned,
                   addr: bus.req_addr, wdata: bus.req_wdata};
        err_q <= req_err;
      end
      if (state == RD) rdata_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)                          nxt = RESP;
        else if (bus.req_we && bus.req_size == SZ_W) nxt = WR;
        else                                  nxt = RD;
      end
      RD:      nxt = rq.we ? WR : RESP;
      WR:      nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  lsu_align u_align (
    .size   (rq.size),
    .lane   (rq.addr[1:0]),
    .uns    (rq.uns),
    .rdata  (rdata_q),
    .wdata  (rq.wdata),
    .ext    (ext),
    .merged (merged)
  );

  // Strobes decode from state alone, so async reset drops them immediately.
  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_read   = (state == RD);
  assign bus.mem_write  = (state == WR);
  assign bus.mem_addr   = {rq.addr[DATA_W-1:2], 2'b00};
  assign bus.mem_wdata  = (state == WR) ? merged : '0;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && err_q;
  assign bus.resp_rdata = (state == RESP && !rq.we && !err_q) ? ext : '0;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table of single accesses against a small dmem model,
// plus reset-in-WR and back-to-back load sequences.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  lsu_if bus();

  lsu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] dmem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_dat = '0;

  always @(posedge clk) begin
    if (bus.mem_write) dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    else if (pl_en)    dmem[pl_idx] <= pl_dat;
  end
  assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wd;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input int rd, input int wr, input logic [31:0] wd);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat; v.rd = rd; v.wr = wr; v.wd = wd;
    return v;
  endfunction

  task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int w, lat, rd, wr;
    logic [31:0] got_d, got_wd;
    logic got_e, abad;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_size = v.sz;
    bus.req_unsigned = v.uns; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    chk({nm, " ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    lat = 0; rd = 0; wr = 0; got_d = '0; got_wd = '0; got_e = 1'b0; abad = 1'b0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // scramble inputs: the captured request must not follow them
        bus.req_valid = 1'b0; bus.req_we = ~v.we; bus.req_size = ~v.sz;
        bus.req_unsigned = ~v.uns; bus.req_addr = ~v.addr; bus.req_wdata = ~v.wdata;
      end
      if (bus.mem_read) rd++;
      if (bus.mem_write) begin wr++; got_wd = bus.mem_wdata; end
      if (bus.mem_read && bus.mem_write) abad = 1'b1;
      if (!bus.mem_write && bus.mem_wdata != 32'h0) abad = 1'b1;
      if ((bus.mem_read || bus.mem_write) && bus.mem_addr != {v.addr[31:2], 2'b00}) abad = 1'b1;
      if (bus.resp_valid) begin lat = k; got_d = bus.resp_rdata; got_e = bus.resp_err; end
    end
    chk({nm, " lat"},   32'(lat), 32'(v.lat));
    chk({nm, " rdata"}, got_d, v.rdata);
    chk({nm, " err"},   32'(got_e), 32'(v.err));
    chk({nm, " nread"}, 32'(rd), 32'(v.rd));
    chk({nm, " nwrite"}, 32'(wr), 32'(v.wr));
    chk({nm, " membus"}, 32'(abad), 32'd0);
    if (v.wr != 0) chk({nm, " wdata"}, got_wd, v.wd);
    @(negedge clk);
    chk({nm, " pulse"}, 32'(bus.resp_valid), 32'd0);
  endtask

  vec_t tv [24];
  int   acc, pulses;
  int   acc_k [2];
  logic [31:0] b2b_exp [2];

  initial begin
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_B;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h55;

    // reset state, with a request held on the inputs
    preload(6'd0, 32'h11223344);
    preload(6'd1, 32'h55667788);
    preload(6'd4, 32'h8899AABB);
    preload(6'd5, 32'h7FFF8001);
    preload(6'd8, 32'hCAFEF00D);
    preload(6'd9, 32'h00000000);
    @(negedge clk);
    chk("rst ready",  32'(bus.req_ready),  32'd1);
    chk("rst mwrite", 32'(bus.mem_write),  32'd0);
    chk("rst mread",  32'(bus.mem_read),   32'd0);
    chk("rst rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rst rerr",   32'(bus.resp_err),   32'd0);
    chk("rst rdata",  bus.resp_rdata, 32'h0);
    chk("rst maddr",  bus.mem_addr,   32'h0);
    chk("rst mwdata", bus.mem_wdata,  32'h0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post-rst idle", 32'({bus.resp_valid, bus.mem_read, bus.mem_write}), 32'd0);
    end

    //        we    size    uns   addr     wdata          rdata          err lat rd wr wd
    tv[0]  = mk(1'b0, SZ_B, 1'b0, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 2, 1, 0, 32'h0);
    tv[1]  = mk(1'b0, SZ_B, 1'b1, 32'h13, 32'h0,        32'h00000088, 1'b0, 2, 1, 0, 32'h0);
    tv[2]  = mk(1'b0, SZ_B, 1'b0, 32'h10, 32'h0,        32'hFFFFFFBB, 1'b0, 2, 1, 0, 32'h0);
    tv[3]  = mk(1'b0, SZ_B, 1'b1, 32'h11, 32'h0,        32'h000000AA, 1'b0, 2, 1, 0, 32'h0);
    tv[4]  = mk(1'b0, SZ_H, 1'b1, 32'h12, 32'h0,        32'h00008899, 1'b0, 2, 1, 0, 32'h0);
    tv[5]  = mk(1'b0, SZ_H, 1'b0, 32'h10, 32'h0,        32'hFFFFAABB, 1'b0, 2, 1, 0, 32'h0);
    tv[6]  = mk(1'b1, SZ_H, 1'b0, 32'h12, 32'h00001234, 32'h0,        1'b0, 3, 1, 1, 32'h1234AABB);
    tv[7]  = mk(1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        32'h1234AABB, 1'b0, 2, 1, 0, 32'h0);
    tv[8]  = mk(1'b1, SZ_W, 1'b0, 32'h21, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'h0);
    tv[9]  = mk(1'b0, SZ_H, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
    tv[10] = mk(1'b0, SZ_W, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
    tv[11] = mk(1'b0, 2'b11, 1'b0, 32'h0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
    tv[12] = mk(1'b1, SZ_B, 1'b0, 32'h21, 32'hFFFFFF5A, 32'h0,        1'b0, 3, 1, 1, 32'hCAFE5A0D);
    tv[13] = mk(1'b1, SZ_W, 1'b0, 32'h24, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF);
    tv[14] = mk(1'b0, SZ_W, 1'b0, 32'h24, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0);
    tv[15] = mk(1'b0, SZ_W, 1'b1, 32'h20, 32'h0,        32'hCAFE5A0D, 1'b0, 2, 1, 0, 32'h0);
    tv[16] = mk(1'b0, SZ_H, 1'b0, 32'h16, 32'h0,        32'h00007FFF, 1'b0, 2, 1, 0, 32'h0);
    tv[17] = mk(1'b0, SZ_H, 1'b0, 32'h14, 32'h0,        32'hFFFF8001, 1'b0, 2, 1, 0, 32'h0);
    tv[18] = mk(1'b0, SZ_B, 1'b0, 32'h15, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0);
    tv[19] = mk(1'b1, SZ_H, 1'b0, 32'h14, 32'h5555ABCD, 32'h0,        1'b0, 3, 1, 1, 32'h7FFFABCD);
    tv[20] = mk(1'b0, SZ_W, 1'b0, 32'h14, 32'h0,        32'h7FFFABCD, 1'b0, 2, 1, 0, 32'h0);
    tv[21] = mk(1'b1, 2'b11, 1'b0, 32'h8, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
    tv[22] = mk(1'b1, SZ_B, 1'b0, 32'h13, 32'h00000011, 32'h0,        1'b0, 3, 1, 1, 32'h1134AABB);
    tv[23] = mk(1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        32'h1134AABB, 1'b0, 2, 1, 0, 32'h0);

    for (int i = 0; i < 24; i++) run_vec($sformatf("v%0d", i), tv[i]);

    // reset while in WR of a byte store: write must not land, no response
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_B;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = 32'h77;
    chk("rstwr ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstwr rd", 32'(bus.mem_read), 32'd1);
    @(negedge clk);
    chk("rstwr wr", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwr wr drop", 32'(bus.mem_write), 32'd0);
    chk("rstwr wdata",   bus.mem_wdata, 32'h0);
    chk("rstwr maddr",   bus.mem_addr, 32'h0);
    chk("rstwr ready0",  32'(bus.req_ready), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstwr no resp", 32'(bus.resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstwr idle", 32'({bus.resp_valid, bus.req_ready}), 32'b01);
    end
    chk("rstwr dmem", dmem[8], 32'hCAFE5A0D);
    run_vec("postrst", mk(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hCAFE5A0D, 1'b0, 2, 1, 0, 32'h0));

    // back-to-back loads with req_valid held
    b2b_exp[0] = 32'h11223344;
    b2b_exp[1] = 32'h55667788;
    acc = 0; pulses = 0; acc_k[0] = 0; acc_k[1] = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_W;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int k = 0; k < 12; k++) begin
      if (acc == 1) bus.req_addr = 32'h4;
      if (acc >= 2) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        if (pulses < 2) chk($sformatf("b2b rdata%0d", pulses), bus.resp_rdata, b2b_exp[pulses]);
        pulses++;
      end
      if (bus.req_valid && bus.req_ready && acc < 2) begin acc_k[acc] = k; acc++; end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b accepts", 32'(acc), 32'd2);
    chk("b2b spacing", 32'(acc_k[1] - acc_k[0]), 32'd3);
    chk("b2b pulses",  32'(pulses), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL use one clock, `clk`, and an active-low asynchronous reset, `rst_n`.
REQ-002 clk  input  1  rising-edge clock shared with dmem.
REQ-003 rst_n  input  1  active-low asynchronous reset.
REQ-004 req_valid  input  1  CPU access request.
REQ-005 req_ready  output  1  request accepted on an edge where req_valid && req_ready.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00=byte, 01=half, 10=word, 11=reserved.
REQ-008 req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned or reserved access, valid with resp_valid.
REQ-014 mem_addr  output  32  word address to dmem: {addr[31:2],2'b00}.
REQ-015 mem_wdata  output  32  full word written to dmem.
REQ-016 mem_write  output  1  dmem write enable.
REQ-017 mem_read  output  1  dmem read enable.
REQ-018 mem_rdata  input  32  dmem combinational read data.

Function
REQ-019 The FSM SHALL have four states: IDLE, RD, WR and RESP.
REQ-020 The FSM SHALL drive req_ready=1 only in IDLE.
REQ-021 On acceptance, the block SHALL capture we, size, unsigned, addr and wdata into registers, and SHALL ignore later changes on the request inputs until the return to IDLE.
REQ-022 An access SHALL be treated as an error when size==11, when size==01 with addr[0]=1, or when size==10 with addr[1:0]!=0; an error access SHALL take the path IDLE->RESP and issue no dmem access.
REQ-023 A load SHALL take the path IDLE->RD->RESP, so resp_valid is asserted 2 cycles after the accept edge.
REQ-024 A word store SHALL take the path IDLE->WR->RESP.
REQ-025 A byte or half store SHALL take the path IDLE->RD->WR->RESP, performing a read-modify-write.
REQ-026 In RD, the block SHALL assert mem_read=1 and SHALL register mem_rdata at the end of the cycle.
REQ-027 In WR, the block SHALL assert mem_write=1 for exactly one cycle.
REQ-028 mem_read and mem_write SHALL be decoded from state only, and SHALL never be asserted together.
REQ-029 Lane selection SHALL be little-endian: byte lane = addr[1:0]; half lane = addr[1] (0 selects bits 15:0, 1 selects bits 31:16).
REQ-030 Merge for byte and half stores SHALL replace only the selected lane of the read word with the low bits of wdata; all other bytes SHALL be preserved.
REQ-031 Load extract SHALL shift the selected lane to bit 0, then sign-extend or zero-extend per the unsigned flag; a word load SHALL pass the data through unchanged.
REQ-032 In RESP, the block SHALL assert resp_valid=1 for one cycle and return to IDLE; the response SHALL have no backpressure.
REQ-033 A new request SHALL be acceptable on the first IDLE cycle after RESP, giving a minimum of 3 cycles between accepts for loads.
REQ-034 mem_wdata SHALL be 0 outside WR.
REQ-035 mem_addr SHALL be held at the captured word address from RD through WR.

Reset
REQ-036 Asserting rst_n=0 SHALL immediately force the state to IDLE and clear all captured registers.
REQ-037 During reset, the outputs SHALL be: mem_write=0, mem_read=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0.
REQ-038 A reset during WR SHALL deassert mem_write asynchronously, so no write occurs at the next edge; an in-flight request SHALL be dropped without a response.
REQ-039 While rst_n=0, req_ready SHALL read 1, since the state is IDLE, but no request SHALL be captured.

Structure
REQ-040 A shared package, lsu_pkg, SHALL hold the size encodings (SZ_B, SZ_H, SZ_W), the state enum, and the data width constant of 32.
REQ-041 Extract and merge SHALL be implemented in one combinational sub-module, lsu_align, instantiated once; the FSM and registers SHALL remain in lsu.

Verification
REQ-042 Preload dmem[0x10]=0x8899AABB; issue a byte load at 0x13 with signed extension -> resp_rdata=0xFFFFFF88 on cycle 2 after accept; the same load with unsigned extension -> 0x00000088.
REQ-043 Issue a half store at 0x12 with wdata=0x1234 to the same word -> one mem_read cycle, then mem_write with mem_wdata=0x1234AABB; a following word load at 0x10 returns 0x1234AABB.
REQ-044 Issue a word store at 0x21 -> resp_err=1 and resp_rdata=0; mem_read and mem_write stay 0 throughout; resp_valid is asserted 1 cycle after accept.
REQ-045 Issue a byte store at 0x20, then drop rst_n low while in WR -> mem_write falls the same cycle; dmem[0x20] is unchanged; no resp_valid; req_ready=1 after release.
REQ-046 Issue back-to-back word loads at 0x0 and 0x4 with req_valid held high -> the second accept occurs exactly 3 cycles after the first, and each load yields one resp_valid pulse.
